dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the byte-enabled data memory (32-bit words, 15-bit word address, separate read/write address ports, `wren`, 4-bit byte enable).
- Accepts one CPU memory request at a time over a valid/ready handshake and decodes RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives the memory's byte enables, lane-shifted write data and addresses.
- Aligns and sign/zero-extends load data, and returns a one-cycle response pulse. Misaligned or illegal requests never reach memory.

Parameters:
- ADDR_W, 15, word-address width driven to memory.
- RD_LAT, 0, clock cycles from `mem_rdaddress` stable to `mem_q` valid (0 = combinational read).

Ports:
- clk  in  1  single clock for all state.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_byteena  out  4  byte enables to memory.
- mem_data  out  32  lane-shifted write data.
- mem_rdaddress  out  ADDR_W  read word address.
- mem_wraddress  out  ADDR_W  write word address.
- mem_wren  out  1  write enable.
- mem_q  in  32  memory read data.

Behaviour:
- Reset (rstn low, asynchronous):
  - State = IDLE.
  - Outputs forced low: resp_valid, resp_err, resp_rdata, mem_wren, mem_byteena, mem_data, both addresses.
  - req_ready = 0 while rstn is low.
  - Reset mid-operation aborts the access: no further `mem_wren`, no response.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge. All request fields are captured in registers at acceptance. Inputs are ignored outside IDLE.
- Address fields:
  - Word address = `req_addr[ADDR_W+1:2]`.
  - Byte offset = `req_addr[1:0]`. Upper address bits above ADDR_W+1 are ignored.
- Legality:
  - Loads: funct3 in {000, 001, 010, 100, 101}.
  - Stores: funct3 in {000, 001, 010}.
  - Halfword requires offset[0]=0; word requires offset=00.
  - Anything else is an error.
- States: IDLE, WRITE, RD_WAIT, RESP.
  - IDLE → WRITE on legal store.
  - IDLE → RD_WAIT on legal load.
  - IDLE → RESP on error.
  - WRITE → RESP after 1 cycle.
  - RD_WAIT → RESP after RD_LAT+1 cycles, using a counter. mem_q is captured on the final RD_WAIT edge.
  - RESP → IDLE after 1 cycle, with resp_valid=1 for exactly that cycle.
- Latency (request accepted at edge T):
  - Store: mem_wren high for exactly the cycle after T; resp_valid in the following cycle (2 cycles total).
  - Load: resp_valid RD_LAT+2 cycles after T.
  - Error: resp_valid 1 cycle after T, resp_err=1, resp_rdata=0. No mem_wren, no address change.
- Store lanes:
  - SB: byteena = 0001 << offset; data = {4{wdata[7:0]}}.
  - SH: byteena = 0011 << offset; data = {2{wdata[15:0]}}.
  - SW: byteena = 1111; data = wdata.
- Memory port sequencing:
  - mem_wraddress and mem_byteena are held stable from WRITE entry through the WRITE cycle, because memory merges non-enabled bytes combinationally.
  - mem_byteena = 0 and mem_wren = 0 in all other states.
- Load extraction:
  - Byte = q >> (8·offset); half = q >> (16·offset[1]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - resp_rdata is held until the next resp_valid.
- mem_rdaddress: driven from the captured word address while in RD_WAIT; otherwise holds its last value.
- Back-to-back: req_ready returns high in the cycle after RESP, so the sustained rate is one request per 3 cycles (store) or RD_LAT+3 cycles (load).

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF, then LW same address (RD_LAT=0): mem_wraddress=4, byteena=1111, wren pulses 1 cycle; load returns 0xDEADBEEF at T+2, resp_err=0.
- SB 0xA5 to addr 0x13 over word 0x11223344: byteena=1000, mem_data=0xA5A5A5A5; LW 0x10 → 0xA5223344; LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- SH 0x8001 to addr 0x22: byteena=1100; LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- LW addr 0x06, then SH addr 0x05, then funct3=011: each gives resp_err=1, resp_rdata=0 at T+1; mem_wren never asserts.
- RD_LAT=2 build, LW: mem_q is sampled 3 cycles after acceptance and resp_valid arrives at T+4; req_valid held high throughout is accepted only when req_ready=1.
- Assert rstn low during WRITE: mem_wren drops immediately and no resp_valid follows. After release, req_ready=1 and a fresh LW completes normally.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit sitting directly in front of a byte-enabled
// 32-bit data memory with separate read/write word-address ports.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req_*              CPU request (valid/ready, we, funct3, byte addr, wdata)
//   resp_*             one-cycle response pulse with extended load data / error
//   mem_*              memory side: byte enables, lane-shifted write data,
//                      read/write word addresses, write enable, read data in
//
// One request is in flight at a time. Misaligned or illegal accesses are
// answered with resp_err and never touch the memory ports.
module dmem_lsu #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned RD_LAT = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [3:0]        mem_byteena,
   output logic [31:0]       mem_data,
   output logic [ADDR_W-1:0] mem_rdaddress,
   output logic [ADDR_W-1:0] mem_wraddress,
   output logic              mem_wren,
   input  logic [31:0]       mem_q
);

   localparam int unsigned CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_RD_WAIT,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic               req_ready_q, req_ready_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [1:0]         off_q, off_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_err_q, resp_err_d;
   logic [31:0]        resp_rdata_q, resp_rdata_d;
   logic [3:0]         byteena_q, byteena_d;
   logic               wren_q, wren_d;
   logic [31:0]        data_q, data_d;
   logic [ADDR_W-1:0]  rdaddr_q, rdaddr_d;
   logic [ADDR_W-1:0]  wraddr_q, wraddr_d;

   logic               accept_c;
   logic [1:0]         off_c;
   logic [ADDR_W-1:0]  word_addr_c;
   logic               legal_c;
   logic [3:0]         be_c;
   logic [31:0]        st_data_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;
   logic [31:0]        load_c;
   logic               unused_addr_c;

   // req_ready_q is only ever high in IDLE, so it alone qualifies acceptance
   assign accept_c      = req_valid & req_ready_q;
   assign off_c         = req_addr[1:0];
   assign word_addr_c   = req_addr[ADDR_W+1:2];
   assign unused_addr_c = ^req_addr[31:ADDR_W+2];

   // Legality: funct3 set depends on direction, then natural alignment
   always_comb begin
      legal_c = 1'b0;
      case (req_funct3)
         3'b000:  legal_c = 1'b1;
         3'b001:  legal_c = ~off_c[0];
         3'b010:  legal_c = (off_c == 2'b00);
         3'b100:  legal_c = ~req_we;
         3'b101:  legal_c = ~req_we & ~off_c[0];
         default: legal_c = 1'b0;
      endcase
   end

   // Store lanes: replicate data across the word, enable only target bytes
   always_comb begin
      be_c      = 4'b1111;
      st_data_c = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_c      = 4'(4'b0001 << off_c);
            st_data_c = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_c      = 4'(4'b0011 << off_c);
            st_data_c = {2{req_wdata[15:0]}};
         end
         default: begin
            be_c      = 4'b1111;
            st_data_c = req_wdata;
         end
      endcase
   end

   // Load extraction and sign/zero extension from the captured request
   always_comb begin
      case (off_q)
         2'd1:    byte_c = mem_q[15:8];
         2'd2:    byte_c = mem_q[23:16];
         2'd3:    byte_c = mem_q[31:24];
         default: byte_c = mem_q[7:0];
      endcase
      half_c = off_q[1] ? mem_q[31:16] : mem_q[15:0];
      case (funct3_q)
         3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  load_c = {{16{half_c[15]}}, half_c};
         3'b100:  load_c = {24'h0, byte_c};
         3'b101:  load_c = {16'h0, half_c};
         default: load_c = mem_q;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      byteena_d    = 4'b0000;
      wren_d       = 1'b0;
      data_d       = data_q;
      rdaddr_d     = rdaddr_q;
      wraddr_d     = wraddr_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               funct3_d = req_funct3;
               off_d    = off_c;
               if (!legal_c) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (req_we) begin
                  // Enables and address are registered together so they are
                  // stable for the whole write cycle
                  state_d   = S_WRITE;
                  wren_d    = 1'b1;
                  byteena_d = be_c;
                  data_d    = st_data_c;
                  wraddr_d  = word_addr_c;
               end else begin
                  state_d  = S_RD_WAIT;
                  cnt_d    = '0;
                  rdaddr_d = word_addr_c;
               end
            end
         end
         S_WRITE: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
         end
         S_RD_WAIT: begin
            // mem_q is captured on the last RD_WAIT edge
            if (cnt_q == CNT_W'(RD_LAT)) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_c;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b0;
         cnt_q        <= '0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         byteena_q    <= 4'b0000;
         wren_q       <= 1'b0;
         data_q       <= 32'h0;
         rdaddr_q     <= '0;
         wraddr_q     <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         cnt_q        <= cnt_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         byteena_q    <= byteena_d;
         wren_q       <= wren_d;
         data_q       <= data_d;
         rdaddr_q     <= rdaddr_d;
         wraddr_q     <= wraddr_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_err      = resp_err_q;
   assign resp_rdata    = resp_rdata_q;
   assign mem_byteena   = byteena_q;
   assign mem_wren      = wren_q;
   assign mem_data      = data_q;
   assign mem_rdaddress = rdaddr_q;
   assign mem_wraddress = wraddr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: instance 0 uses a combinational-read memory
// (RD_LAT=0), instance 1 a two-cycle-latency memory (RD_LAT=2).
module tb_dmem_lsu;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;

   logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_err, mem_wren;
   logic [2:0]  req_funct3    [2];
   logic [31:0] req_addr      [2];
   logic [31:0] req_wdata     [2];
   logic [31:0] resp_rdata    [2];
   logic [31:0] mem_data      [2];
   logic [31:0] mem_q         [2];
   logic [3:0]  mem_byteena   [2];
   logic [14:0] mem_rdaddress [2];
   logic [14:0] mem_wraddress [2];

   logic [31:0] mem0 [0:32767];
   logic [31:0] mem1 [0:32767];
   logic [31:0] p1, p2;

   int          checks = 0;
   int          errors = 0;
   int          wren_tot [2];
   int          resp_tot [2];
   logic [3:0]  last_be   [2];
   logic [31:0] last_data [2];
   logic [14:0] last_wa   [2];

   logic [32:0] sb0 [$];
   logic [32:0] sb1 [$];
   int          acc_q [$];
   int          n_acc, lat, rc0;
   logic [32:0] got;

   always #5 clk = ~clk;

   dmem_lsu #(.ADDR_W(15), .RD_LAT(0)) u_dut0 (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .mem_byteena(mem_byteena[0]), .mem_data(mem_data[0]),
      .mem_rdaddress(mem_rdaddress[0]), .mem_wraddress(mem_wraddress[0]),
      .mem_wren(mem_wren[0]), .mem_q(mem_q[0])
   );

   dmem_lsu #(.ADDR_W(15), .RD_LAT(2)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .mem_byteena(mem_byteena[1]), .mem_data(mem_data[1]),
      .mem_rdaddress(mem_rdaddress[1]), .mem_wraddress(mem_wraddress[1]),
      .mem_wren(mem_wren[1]), .mem_q(mem_q[1])
   );

   // Byte-enabled memory models; instance 1 reads through a 2-stage pipe
   always @(posedge clk) begin
      if (mem_wren[0])
         for (int b = 0; b < 4; b++)
            if (mem_byteena[0][b]) mem0[mem_wraddress[0]][8*b +: 8] <= mem_data[0][8*b +: 8];
      if (mem_wren[1])
         for (int b = 0; b < 4; b++)
            if (mem_byteena[1][b]) mem1[mem_wraddress[1]][8*b +: 8] <= mem_data[1][8*b +: 8];
      p1 <= mem1[mem_rdaddress[1]];
      p2 <= p1;
   end
   assign mem_q[0] = mem0[mem_rdaddress[0]];
   assign mem_q[1] = p2;

   // Bus monitor: counts write pulses / responses and records the last write
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (mem_wren[s]) begin
            wren_tot[s]++;
            last_be[s]   = mem_byteena[s];
            last_data[s] = mem_data[s];
            last_wa[s]   = mem_wraddress[s];
         end
         if (resp_valid[s]) resp_tot[s]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on instance sel; expected result goes through the scoreboard
   task automatic do_req(input int sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat);
      int          k;
      int          w0;
      logic [14:0] ra0, wa0;
      logic [32:0] e;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);
      chk("resp_pulse_end", 32'(resp_valid[sel]), 32'd0);
      w0  = wren_tot[sel];
      ra0 = mem_rdaddress[sel];
      wa0 = mem_wraddress[sel];
      req_valid[sel]  = 1'b1;
      req_we[sel]     = we;
      req_funct3[sel] = f3;
      req_addr[sel]   = addr;
      req_wdata[sel]  = wdata;
      if (sel == 0) sb0.push_back({exp_err, exp_rdata});
      else          sb1.push_back({exp_err, exp_rdata});
      @(negedge clk);
      req_valid[sel] = 1'b0;
      k = 1;
      while (!resp_valid[sel] && k < 16) begin
         @(negedge clk);
         k++;
      end
      chk("resp_seen", 32'(resp_valid[sel]), 32'd1);
      if (sel == 0) e = sb0.pop_front();
      else          e = sb1.pop_front();
      if (resp_valid[sel]) begin
         chk("resp_err", 32'(resp_err[sel]), 32'(e[32]));
         chk("resp_rdata", resp_rdata[sel], e[31:0]);
         chk("resp_latency", 32'(k), 32'(exp_lat));
      end
      chk("wren_pulses", 32'(wren_tot[sel] - w0), (we && !exp_err) ? 32'd1 : 32'd0);
      if (exp_err) begin
         chk("err_rdaddr_kept", 32'(mem_rdaddress[sel]), 32'(ra0));
         chk("err_wraddr_kept", 32'(mem_wraddress[sel]), 32'(wa0));
      end
   endtask

   initial begin
      req_valid = 2'b00;
      req_we    = 2'b00;
      for (int s = 0; s < 2; s++) begin
         req_funct3[s] = 3'b000;
         req_addr[s]   = 32'h0;
         req_wdata[s]  = 32'h0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_ctl", {26'h0, resp_valid[0], resp_err[0], mem_byteena[0]}, 32'h0);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_rdata", resp_rdata[0], 32'h0);
      chk("rst_mdata", mem_data[0], 32'h0);
      chk("rst_addrs", {2'b00, mem_rdaddress[0], mem_wraddress[0]}, 32'h0);
      rstn = 1'b1;

      // SW / LW round trip
      do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
      chk("sw_wa", 32'(last_wa[0]), 32'd4);
      chk("sw_be", 32'(last_be[0]), 32'hF);
      chk("sw_data", last_data[0], 32'hDEADBEEF);
      do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);

      // SB into the top lane of 0x11223344
      do_req(0, 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0, 2);
      do_req(0, 1'b1, 3'b000, 32'h13, 32'h123456A5, 1'b0, 32'h0, 2);
      chk("sb_be", 32'(last_be[0]), 32'h8);
      chk("sb_data", last_data[0], 32'hA5A5A5A5);
      do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hA5223344, 2);
      do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFA5, 2);
      do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000A5, 2);

      // SH upper half, SB lane 1, halfword / byte loads
      do_req(0, 1'b1, 3'b001, 32'h22, 32'hFFFF8001, 1'b0, 32'h0, 2);
      chk("sh_be", 32'(last_be[0]), 32'hC);
      chk("sh_data", last_data[0], 32'h80018001);
      chk("sh_wa", 32'(last_wa[0]), 32'd8);
      do_req(0, 1'b1, 3'b000, 32'h21, 32'h0000007E, 1'b0, 32'h0, 2);
      chk("sb1_be", 32'(last_be[0]), 32'h2);
      do_req(0, 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF8001, 2);
      do_req(0, 1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 32'h0000007E, 2);
      do_req(0, 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h00008001, 2);
      @(negedge clk);
      chk("rdata_hold", resp_rdata[0], 32'h00008001);

      // Upper address bits ignored
      do_req(0, 1'b0, 3'b010, 32'hFFFE0010, 32'h0, 1'b0, 32'hA5223344, 2);

      // Errors: misaligned LW, misaligned SH, funct3 011, store with LBU code
      do_req(0, 1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1);
      do_req(0, 1'b1, 3'b001, 32'h05, 32'h12345678, 1'b1, 32'h0, 1);
      do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1);
      do_req(0, 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 1);
      do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hA5223344, 2);

      // Reset asserted during WRITE aborts the store and its response
      @(negedge clk);
      rc0 = resp_tot[0];
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
      req_addr[0] = 32'h30; req_wdata[0] = 32'h55;
      @(negedge clk);
      req_valid[0] = 1'b0;
      #2;
      chk("rst_wr_wren_before", 32'(mem_wren[0]), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rst_wr_wren_drop", 32'(mem_wren[0]), 32'd0);
      chk("rst_wr_ready", 32'(req_ready[0]), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wr_no_resp", 32'(resp_tot[0] - rc0), 32'd0);
      chk("rst_wr_ready_back", 32'(req_ready[0]), 32'd1);
      do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hA5223344, 2);

      // RD_LAT=2 instance: preload, then a load request held valid
      do_req(1, 1'b1, 3'b010, 32'h00, 32'h11111111, 1'b0, 32'h0, 2);
      do_req(1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 2);
      req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h20; req_wdata[1] = 32'h0;
      n_acc = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (resp_valid[1]) begin
            if (acc_q.size() != 0 && sb1.size() != 0) begin
               lat = n - acc_q.pop_front();
               got = sb1.pop_front();
               chk("hold_latency", 32'(lat), 32'd4);
               chk("hold_rdata", resp_rdata[1], got[31:0]);
               chk("hold_err", 32'(resp_err[1]), 32'(got[32]));
            end else begin
               chk("hold_spurious_resp", 32'(resp_valid[1]), 32'd0);
            end
         end else if (acc_q.size() != 0) begin
            chk("hold_ready_busy", 32'(req_ready[1]), 32'd0);
         end
         req_valid[1] = (n < 10);
         if (req_valid[1] && req_ready[1]) begin
            acc_q.push_back(n);
            sb1.push_back({1'b0, 32'hCAFEF00D});
            n_acc++;
         end
      end
      req_valid[1] = 1'b0;
      chk("hold_accepts", 32'(n_acc), 32'd2);
      chk("hold_pending", 32'(acc_q.size()), 32'd0);
      chk("sb0_empty", 32'(sb0.size()), 32'd0);
      chk("sb1_empty", 32'(sb1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
